creg_tile_agen: RTL and testbench

Parametrised tile-order address generator for the C-result buffer of the matrix-multiply datapath. On `start` it walks a ROWS×COLS matrix in TILE_R×TILE_C tiles and emits one buffer address per accepted handshake, with run-time selectable tile ordering and base offset. It sits between the MAC array's result sequencer, which drives `ready`, and the C-buffer write port. It replaces the fixed 8×8 / 2×2 generator.

---
 rtl/creg_tile_agen.sv | 152 +++++++++++++++
 tb/tb_creg_tile_agen.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/creg_tile_agen.sv
// Tile-order address generator for the C-result buffer: walks a ROWS x COLS
// matrix tile by tile and emits one address per valid/ready handshake.
module creg_tile_agen #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int TILE_R = 2,
    parameter int TILE_C = 2,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              col_major,
    input  logic              abort,
    input  logic              ready,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              tile_last,
    output logic              busy,
    output logic              done
);

    localparam int TR_W  = (ROWS > 1)   ? $clog2(ROWS)   : 1;
    localparam int TC_W  = (COLS > 1)   ? $clog2(COLS)   : 1;
    localparam int IR_W  = (TILE_R > 1) ? $clog2(TILE_R) : 1;
    localparam int IC_W  = (TILE_C > 1) ? $clog2(TILE_C) : 1;
    localparam int SUM_W = ADDR_W + TR_W + TC_W + 2;

    localparam logic [TR_W-1:0] TR_LAST = TR_W'(ROWS - TILE_R);
    localparam logic [TC_W-1:0] TC_LAST = TC_W'(COLS - TILE_C);
    localparam logic [IR_W-1:0] IR_LAST = IR_W'(TILE_R - 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(TILE_C - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              cm_q, cm_d;
    logic [TR_W-1:0]   tr_q, tr_d;
    logic [TC_W-1:0]   tc_q, tc_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [IC_W-1:0]   ic_q, ic_d;

    logic ir_end, ic_end, tr_end, tc_end, tile_end, final_elem;
    logic [SUM_W-1:0] row_w, col_w;

    assign ir_end     = (ir_q == IR_LAST);
    assign ic_end     = (ic_q == IC_LAST);
    assign tr_end     = (tr_q == TR_LAST);
    assign tc_end     = (tc_q == TC_LAST);
    assign tile_end   = ir_end & ic_end;
    assign final_elem = tile_end & tr_end & tc_end;

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cm_d    = cm_q;
        tr_d    = tr_q;
        tc_d    = tc_q;
        ir_d    = ir_q;
        ic_d    = ic_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    base_d  = base_addr;
                    cm_d    = col_major;
                    tr_d    = '0;
                    tc_d    = '0;
                    ir_d    = '0;
                    ic_d    = '0;
                end
            end
            S_RUN: begin
                // abort wins: the address shown this cycle is not consumed
                if (abort) begin
                    state_d = S_IDLE;
                end else if (ready) begin
                    if (final_elem) begin
                        state_d = S_DONE;
                        tr_d    = '0;
                        tc_d    = '0;
                        ir_d    = '0;
                        ic_d    = '0;
                    end else if (!ir_end) begin
                        ir_d = ir_q + IR_W'(1);
                    end else begin
                        ir_d = '0;
                        if (!ic_end) begin
                            ic_d = ic_q + IC_W'(1);
                        end else begin
                            ic_d = '0;
                            if (cm_q) begin
                                if (tr_end) begin
                                    tr_d = '0;
                                    tc_d = tc_q + TC_W'(TILE_C);
                                end else begin
                                    tr_d = tr_q + TR_W'(TILE_R);
                                end
                            end else begin
                                if (tc_end) begin
                                    tc_d = '0;
                                    tr_d = tr_q + TR_W'(TILE_R);
                                end else begin
                                    tc_d = tc_q + TC_W'(TILE_C);
                                end
                            end
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            cm_q    <= 1'b0;
            tr_q    <= '0;
            tc_q    <= '0;
            ir_q    <= '0;
            ic_q    <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cm_q    <= cm_d;
            tr_q    <= tr_d;
            tc_q    <= tc_d;
            ir_q    <= ir_d;
            ic_q    <= ic_d;
        end
    end

    // Full-width sum, truncated only at the output so wrap is modulo 2^ADDR_W
    assign row_w = SUM_W'(tr_q) + SUM_W'(ir_q);
    assign col_w = SUM_W'(tc_q) + SUM_W'(ic_q);
    assign addr  = ADDR_W'(SUM_W'(base_q) + row_w * SUM_W'(COLS) + col_w);

    assign valid     = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign tile_last = valid & tile_end;

endmodule

// File: tb/tb_creg_tile_agen.sv
// Bench for creg_tile_agen: default 8x8/2x2 instance and a 4x6/1x3 instance
// driven side by side and compared against a nested-loop tile-walk model.
module tb_creg_tile_agen;

    logic       clk = 1'b0;
    logic       reset_n, start, col_major, abort, ready;
    logic [7:0] base_addr;

    logic [7:0] addr_a, addr_b;
    logic       valid_a, tl_a, busy_a, done_a;
    logic       valid_b, tl_b, busy_b, done_b;

    int n_checks = 0;
    int n_errors = 0;

    int exp_addr [2][64];
    bit exp_tl   [2][64];
    int len  [2];
    int idx  [2];
    int post [2];
    bit stall[2];
    int prev_addr[2];

    always #5 clk = ~clk;

    creg_tile_agen dut_a (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .col_major(col_major), .abort(abort), .ready(ready),
        .addr(addr_a), .valid(valid_a), .tile_last(tl_a), .busy(busy_a), .done(done_a)
    );

    creg_tile_agen #(.ROWS(4), .COLS(6), .TILE_R(1), .TILE_C(3), .ADDR_W(8)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .col_major(col_major), .abort(abort), .ready(ready),
        .addr(addr_b), .valid(valid_b), .tile_last(tl_b), .busy(busy_b), .done(done_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: enumerate tiles in the chosen order, then elements column-major inside each.
    task automatic gen(input int w, input int rows, input int cols, input int th,
                       input int tw, input bit cm, input int base);
        int n = 0;
        int tiles_r = rows / th;
        int tiles_c = cols / tw;
        for (int t = 0; t < tiles_r * tiles_c; t++) begin
            int r0 = cm ? (t % tiles_r) * th : (t / tiles_c) * th;
            int c0 = cm ? (t / tiles_r) * tw : (t % tiles_c) * tw;
            for (int ic = 0; ic < tw; ic++) begin
                for (int ir = 0; ir < th; ir++) begin
                    exp_addr[w][n] = (base + (r0 + ir) * cols + c0 + ic) % 256;
                    exp_tl[w][n]   = (ir == th - 1) && (ic == tw - 1);
                    n++;
                end
            end
        end
        len[w] = n;
    endtask

    task automatic observe(input int w, input logic v, input logic [7:0] a,
                           input logic tl, input logic dn, input logic bs);
        string p = (w == 0) ? "a_" : "b_";
        if (idx[w] < len[w]) begin
            check_eq({p, "valid"}, 32'(v), 32'd1);
            check_eq({p, "busy"}, 32'(bs), 32'd1);
            check_eq({p, "addr"}, 32'(a), 32'(exp_addr[w][idx[w]]));
            check_eq({p, "tile_last"}, 32'(tl), 32'(exp_tl[w][idx[w]]));
            if (stall[w]) check_eq({p, "stall_addr"}, 32'(a), 32'(prev_addr[w]));
            prev_addr[w] = int'(a);
            stall[w] = !ready;
            if (ready && !abort) idx[w]++;
        end else if (post[w] == 0) begin
            check_eq({p, "done_pulse"}, 32'(dn), 32'd1);
            check_eq({p, "valid_end"}, 32'(v), 32'd0);
            check_eq({p, "busy_end"}, 32'(bs), 32'd0);
            post[w] = 1;
        end else if (post[w] == 1) begin
            check_eq({p, "done_clear"}, 32'(dn), 32'd0);
            check_eq({p, "valid_idle"}, 32'(v), 32'd0);
            check_eq({p, "busy_idle"}, 32'(bs), 32'd0);
            post[w] = 2;
        end else begin
            check_eq({p, "valid_idle"}, 32'(v), 32'd0);
        end
    endtask

    task automatic run_pass(input int base, input bit cm, input bit rnd,
                            input int abort_at, input bit mid_start);
        bit aborted  = 0;
        bit finished = 0;
        gen(0, 8, 8, 2, 2, cm, base);
        gen(1, 4, 6, 1, 3, cm, base);
        for (int w = 0; w < 2; w++) begin
            idx[w] = 0; post[w] = 0; stall[w] = 0; prev_addr[w] = 0;
        end
        base_addr = 8'(base);
        col_major = cm;
        abort     = 1'b0;
        start     = 1'b1;
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            @(negedge clk);
            start     = 1'b0;
            base_addr = 8'($urandom);
            col_major = 1'($urandom);
            if (aborted) begin
                check_eq("a_valid_abort", 32'(valid_a), 32'd0);
                check_eq("a_busy_abort", 32'(busy_a), 32'd0);
                check_eq("a_done_abort", 32'(done_a), 32'd0);
                check_eq("b_valid_abort", 32'(valid_b), 32'd0);
                check_eq("b_done_abort", 32'(done_b), 32'd0);
                abort    = 1'b0;
                ready    = 1'b1;
                finished = 1;
            end else begin
                ready = rnd ? 1'($urandom) : 1'b1;
                abort = (abort_at >= 0) && (idx[0] == abort_at);
                if (abort) ready = 1'b1;
                if (mid_start && idx[0] == 20) start = 1'b1;
                observe(0, valid_a, addr_a, tl_a, done_a, busy_a);
                observe(1, valid_b, addr_b, tl_b, done_b, busy_b);
                if (abort) aborted = 1;
                if (post[0] == 2 && post[1] == 2) finished = 1;
            end
        end
        if (!finished) check_eq("pass_timeout", 32'd0, 32'd1);
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_a_valid"}, 32'(valid_a), 32'd0);
        check_eq({tag, "_a_busy"}, 32'(busy_a), 32'd0);
        check_eq({tag, "_a_done"}, 32'(done_a), 32'd0);
        check_eq({tag, "_a_tlast"}, 32'(tl_a), 32'd0);
        check_eq({tag, "_a_addr"}, 32'(addr_a), 32'd0);
        check_eq({tag, "_b_valid"}, 32'(valid_b), 32'd0);
        check_eq({tag, "_b_addr"}, 32'(addr_b), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        ready     = 1'b1;
        col_major = 1'b1;
        base_addr = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run_pass(0, 1'b1, 1'b0, -1, 1'b0);
        run_pass(0, 1'b0, 1'b0, -1, 1'b0);
        run_pass(0, 1'b1, 1'b1, -1, 1'b0);
        run_pass(250, 1'b1, 1'b0, -1, 1'b0);
        run_pass(5, 1'b1, 1'b1, -1, 1'b1);
        run_pass(17, 1'b0, 1'b0, 9, 1'b0);
        run_pass(17, 1'b0, 1'b0, -1, 1'b0);

        // Reset in the middle of a pass
        base_addr = 8'd37;
        col_major = 1'b1;
        start     = 1'b1;
        ready     = 1'b1;
        repeat (12) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        reset_n = 1'b1;

        run_pass(99, 1'b1, 1'b1, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
